enc8x3_req_2x: RTL and testbench

- Registered 8-to-3 request encoder; the inverse of the team's 3-to-8 enable decoder.
- Captures one-hot or multi-hot request lines Y0..Y7 into a sticky pending register.
- Presents the binary index of the highest-priority pending line on A2..A0 with a VALID/READY handshake.
- Sits in front of the decoder path, so that a downstream consumer can re-decode the index back to a line select.

---
 rtl/enc8x3_req_2x_pkg.sv | 17 +
 rtl/enc8x3_req_2x_penc8x3.sv | 23 ++
 rtl/enc8x3_req_2x.sv | 112 +++++++++++
 tb/tb_enc8x3_req_2x.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/enc8x3_req_2x_pkg.sv
// Shared constants, state encoding and helpers for the 8-to-3 request encoder
// and its companion 3-to-8 decoder path.
package enc_dec_pkg;

  localparam int unsigned N_LINES = 8;
  localparam int unsigned CODE_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [N_LINES-1:0] onehot(input logic [CODE_W-1:0] idx);
    onehot = N_LINES'(1) << idx;
  endfunction

endpackage

// File: rtl/enc8x3_req_2x_penc8x3.sv
// Combinational masked priority encoder: searches downward from `start`,
// wrapping 0 -> 7, and returns the first set bit of `vec`.
module penc8x3
  import enc_dec_pkg::*;
(
  input  logic [N_LINES-1:0] vec,
  input  logic [CODE_W-1:0]  start,
  output logic [CODE_W-1:0]  idx,
  output logic               found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N_LINES; k++) begin
      if (!found && vec[start - CODE_W'(k)]) begin
        idx   = start - CODE_W'(k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/enc8x3_req_2x.sv
// Registered 8-to-3 request encoder with sticky pending lines and a VALID/READY
// grant handshake. Define ENC_ROUND_ROBIN_EN for rotating priority.
module enc8x3_req_2x
  import enc_dec_pkg::*;
(
  input  logic CLK,
  input  logic RSTB,
  input  logic EN,
  input  logic Y0,
  input  logic Y1,
  input  logic Y2,
  input  logic Y3,
  input  logic Y4,
  input  logic Y5,
  input  logic Y6,
  input  logic Y7,
  input  logic READY,
  output logic A0,
  output logic A1,
  output logic A2,
  output logic VALID,
  output logic OVF,
  output logic PEND_ANY
);

  logic [N_LINES-1:0] req;
  logic [N_LINES-1:0] pend;
  logic [N_LINES-1:0] set;
  logic [N_LINES-1:0] clr;
  logic [N_LINES-1:0] avail;
  logic [CODE_W-1:0]  a;
  logic [CODE_W-1:0]  sel_idx;
  logic [CODE_W-1:0]  start;
  logic               valid;
  logic               ovf;
  logic               found;
  logic               handshake;
  state_t             state;

  assign req       = {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0};
  assign handshake = valid & READY;
  assign set       = EN ? req : '0;
  assign clr       = handshake ? onehot(a) : '0;
  // The line being granted is excluded from selection this cycle even if re-requested.
  assign avail     = pend & ~clr;

`ifdef ENC_ROUND_ROBIN_EN
  logic [CODE_W-1:0] last;

  // On a handshake the index just granted becomes the new rotation origin.
  assign start = (handshake ? a : last) - CODE_W'(1);

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      last <= '1;
    end else if (handshake) begin
      last <= a;
    end
  end
`else
  assign start = CODE_W'(N_LINES - 1);
`endif

  penc8x3 u_penc (
    .vec   (avail),
    .start (start),
    .idx   (sel_idx),
    .found (found)
  );

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      pend  <= '0;
      a     <= '0;
      valid <= 1'b0;
      ovf   <= 1'b0;
      state <= IDLE;
    end else begin
      pend <= avail | set;
      ovf  <= |(set & avail);
      case (state)
        IDLE: begin
          if (found) begin
            a     <= sel_idx;
            valid <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (READY) begin
            if (found) begin
              a <= sel_idx;
            end else begin
              valid <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign {A2, A1, A0} = a;
  assign VALID        = valid;
  assign OVF          = ovf;
  assign PEND_ANY     = |pend;

endmodule

// File: tb/tb_enc8x3_req_2x.sv
// Self-checking bench for enc8x3_req_2x (fixed-priority build).
module tb_enc8x3_req_2x;

  logic       CLK = 1'b0;
  logic       RSTB;
  logic       EN;
  logic       READY;
  logic [7:0] y;
  logic       A0, A1, A2, VALID, OVF, PEND_ANY;
  logic [2:0] a_out;

  int compared   = 0;
  int mismatched = 0;

  bit [7:0] m_pend;
  bit       m_valid;
  int       m_a;
  bit       m_ovf;

  typedef struct {
    bit       en;
    bit [7:0] y;
    bit       rdy;
    bit       valid;
    int       a;
    bit       ovf;
    bit       pa;
  } vec_t;

  vec_t tbl[18];

  always #5 CLK = ~CLK;

  assign a_out = {A2, A1, A0};

  enc8x3_req_2x dut (
    .CLK      (CLK),
    .RSTB     (RSTB),
    .EN       (EN),
    .Y0       (y[0]),
    .Y1       (y[1]),
    .Y2       (y[2]),
    .Y3       (y[3]),
    .Y4       (y[4]),
    .Y5       (y[5]),
    .Y6       (y[6]),
    .Y7       (y[7]),
    .READY    (READY),
    .A0       (A0),
    .A1       (A1),
    .A2       (A2),
    .VALID    (VALID),
    .OVF      (OVF),
    .PEND_ANY (PEND_ANY)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend  = '0;
    m_valid = 1'b0;
    m_a     = 0;
    m_ovf   = 1'b0;
  endtask

  // Behavioural model: lines are a set of pending requests; a grant retires
  // the granted line and the highest remaining pending line is offered next.
  task automatic model_step(input bit en, input bit [7:0] yv, input bit rdy);
    bit [7:0] keep;
    bit       hs;
    int       granted;
    bit       ovf_n;
    hs      = m_valid && rdy;
    granted = hs ? m_a : -1;
    ovf_n   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      keep[i] = m_pend[i] && (i != granted);
      if (en && yv[i] && keep[i]) ovf_n = 1'b1;
    end
    if (!m_valid || hs) begin
      m_valid = 1'b0;
      for (int i = 7; i >= 0; i--) begin
        if (keep[i] && !m_valid) begin
          m_valid = 1'b1;
          m_a     = i;
        end
      end
    end
    for (int i = 0; i < 8; i++) m_pend[i] = keep[i] || (en && yv[i]);
    m_ovf = ovf_n;
  endtask

  task automatic cycle(input bit en, input bit [7:0] yv, input bit rdy);
    @(negedge CLK);
    EN    = en;
    y     = yv;
    READY = rdy;
    model_step(en, yv, rdy);
    @(posedge CLK);
    #1;
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_valid"}, 32'(VALID), 32'(m_valid));
    if (m_valid) check({tag, "_a"}, 32'(a_out), 32'(m_a));
    check({tag, "_ovf"}, 32'(OVF), 32'(m_ovf));
    check({tag, "_pend_any"}, 32'(PEND_ANY), 32'(|m_pend));
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RSTB  = 1'b0;
    EN    = 1'b0;
    y     = '0;
    READY = 1'b0;
    model_reset();
    #2;
    check("rst_valid", 32'(VALID), 0);
    check("rst_a", 32'(a_out), 0);
    check("rst_ovf", 32'(OVF), 0);
    check("rst_pend_any", 32'(PEND_ANY), 0);
    @(negedge CLK);
    RSTB = 1'b1;
  endtask

  initial begin
    int vcount;
    RSTB  = 1'b0;
    EN    = 1'b0;
    y     = '0;
    READY = 1'b0;
    model_reset();

    tbl[0]  = '{1'b1, 8'h20, 1'b1, 1'b0, 0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 5, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 8'h01, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 8'h01, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 8'h08, 1'b0, 1'b0, 0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 8'h08, 1'b0, 1'b1, 3, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 8'h09, 1'b0, 1'b0, 0, 1'b0, 1'b1};
    for (int i = 11; i <= 15; i++) tbl[i] = '{1'b0, 8'h00, 1'b0, 1'b1, 3, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0};

    do_reset();

    // Scripted vectors: single grant, EN=0 ignore, OVF merge, held index.
    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].en, tbl[i].y, tbl[i].rdy);
      check($sformatf("tbl%0d_valid", i), 32'(VALID), 32'(tbl[i].valid));
      if (tbl[i].valid) check($sformatf("tbl%0d_a", i), 32'(a_out), 32'(tbl[i].a));
      check($sformatf("tbl%0d_ovf", i), 32'(OVF), 32'(tbl[i].ovf));
      check($sformatf("tbl%0d_pend_any", i), 32'(PEND_ANY), 32'(tbl[i].pa));
    end

    // Full drain: 7..0 back to back, VALID high exactly 8 cycles.
    do_reset();
    cycle(1'b1, 8'hFF, 1'b1);
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      if (VALID) vcount++;
      if (i < 8) check($sformatf("drain_a%0d", i), 32'(a_out), 32'(7 - i));
    end
    check("drain_valid_cycles", 32'(vcount), 8);
    check("drain_pend_any", 32'(PEND_ANY), 0);

    // Asynchronous reset mid-drain after three grants.
    do_reset();
    cycle(1'b1, 8'hFF, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    check("midrst_pre_a", 32'(a_out), 5);
    #2;
    RSTB = 1'b0;
    model_reset();
    #1;
    check("midrst_valid", 32'(VALID), 0);
    check("midrst_a", 32'(a_out), 0);
    check("midrst_ovf", 32'(OVF), 0);
    check("midrst_pend_any", 32'(PEND_ANY), 0);
    @(negedge CLK);
    RSTB = 1'b1;
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      if (VALID || PEND_ANY) vcount++;
    end
    check("midrst_no_grants", 32'(vcount), 0);

    // Randomized traffic against the behavioural model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 4) != 0, 8'($urandom & $urandom & $urandom), ($urandom % 3) != 0);
      compare_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
